// File: rtl/ccip_intr_sched_pkg.sv
// Shared types and sizes for the CCI-P interrupt scheduler.
package ccip_intr_sched_pkg;

  localparam int unsigned NUM_INTR_ID = 4;
  localparam int unsigned INTR_ID_W   = 2;
  localparam int unsigned TIMER_W     = 16;
  localparam int unsigned STAT_W      = 16;

  typedef logic [INTR_ID_W-1:0] t_intr_id;
  typedef logic [TIMER_W-1:0]   t_intr_timer;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    WAIT = 2'd2
  } t_intr_state;

  // Interrupt request beat presented to the c1 Tx mux.
  typedef struct packed {
    logic     valid;
    t_intr_id id;
  } t_intr_tx;

endpackage

// File: rtl/ccip_intr_scheduler_arb.sv
// Round-robin arbiter over pending interrupt IDs; owns the last-grant pointer.
module intr_rr_arbiter
  import ccip_intr_sched_pkg::*;
#(
  parameter int unsigned NUM_ID = NUM_INTR_ID
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_ID-1:0] req_i,
  input  logic              gnt_en_i,
  output logic [NUM_ID-1:0] gnt_oh_c,
  output t_intr_id          gnt_id_c,
  output logic              gnt_vld_c
);

  t_intr_id ptr_q;
  t_intr_id idx;
  logic     found;

  // Search starts at the ID after the last grant and wraps once.
  always_comb begin
    gnt_oh_c = '0;
    gnt_id_c = ptr_q;
    found    = 1'b0;
    idx      = ptr_q;
    for (int unsigned k = 1; k <= NUM_ID; k++) begin
      idx = t_intr_id'(32'(ptr_q) + k);
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt_id_c = idx;
      end
    end
    gnt_vld_c          = found & gnt_en_i;
    gnt_oh_c[gnt_id_c] = gnt_vld_c;
  end

  // Pointer advances only on an actual grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_vld_c) begin
      ptr_q <= gnt_id_c;
    end
  end

endmodule

// File: rtl/ccip_intr_scheduler.sv
// CCI-P c1 interrupt scheduler: per-ID request/issue/response sequencing,
// request coalescing and response timeout.
// Optional per-ID issue and coalesce statistics: define INTR_SCHED_STATS_EN.
module ccip_intr_scheduler
  import ccip_intr_sched_pkg::*;
#(
  parameter int unsigned NUM_ID         = NUM_INTR_ID,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     Clk_400,
  input  logic                     SoftReset_n,
  input  logic [NUM_ID-1:0]        intr_req,
  input  logic                     c1_busy,
  input  logic                     c1TxAlmFull,
  output logic                     c1_tx_valid,
  output t_intr_id                 c1_tx_intr_id,
  input  logic                     c1_rsp_intr_valid,
  input  t_intr_id                 c1_rsp_intr_id,
  input  logic                     err_clr,
  output logic [NUM_ID-1:0]        pending,
  output logic [NUM_ID-1:0]        outstanding,
  output logic [NUM_ID-1:0]        err_timeout,
  output logic                     err_spurious
`ifdef INTR_SCHED_STATS_EN
  ,
  output logic [NUM_ID*STAT_W-1:0] stats_issue_cnt,
  output logic [STAT_W-1:0]        stats_coalesce_cnt
`endif
);

  // Timer value in the last WAIT cycle; the expiring edge leaves WAIT.
  localparam t_intr_timer TO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  t_intr_state       state_q [NUM_ID];
  t_intr_state       state_d [NUM_ID];
  t_intr_timer       timer_q [NUM_ID];
  t_intr_timer       timer_d [NUM_ID];
  logic [NUM_ID-1:0] rearm_q, rearm_d;
  logic [NUM_ID-1:0] err_to_q, err_to_d;
  logic              err_sp_q, err_sp_d;
  logic [NUM_ID-1:0] pend_q, pend_d;
  logic [NUM_ID-1:0] outst_q, outst_d;
  t_intr_tx          tx_q, tx_d;

  logic [NUM_ID-1:0] pend_req_c;
  logic [NUM_ID-1:0] gnt_oh_c;
  t_intr_id          gnt_id_c;
  logic              gnt_vld_c;
  logic              rsp_hit, expire, rearm_nxt;

  // IDs in PEND compete for the channel.
  always_comb begin
    pend_req_c = '0;
    for (int unsigned i = 0; i < NUM_ID; i++) begin
      pend_req_c[i] = (state_q[i] == PEND);
    end
  end

  intr_rr_arbiter #(
    .NUM_ID (NUM_ID)
  ) u_arb (
    .clk       (Clk_400),
    .rst_n     (SoftReset_n),
    .req_i     (pend_req_c),
    .gnt_en_i  (!c1_busy && !c1TxAlmFull),
    .gnt_oh_c  (gnt_oh_c),
    .gnt_id_c  (gnt_id_c),
    .gnt_vld_c (gnt_vld_c)
  );

  // Per-ID next state, timers, rearm and sticky errors.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rearm_d   = rearm_q;
    err_to_d  = err_to_q & ~{NUM_ID{err_clr}};
    err_sp_d  = err_sp_q & ~err_clr;
    rsp_hit   = 1'b0;
    expire    = 1'b0;
    rearm_nxt = 1'b0;
    pend_d    = '0;
    outst_d   = '0;

    if (c1_rsp_intr_valid && (state_q[c1_rsp_intr_id] != WAIT)) begin
      err_sp_d = 1'b1;
    end

    for (int unsigned i = 0; i < NUM_ID; i++) begin
      rsp_hit   = c1_rsp_intr_valid && (c1_rsp_intr_id == t_intr_id'(i));
      expire    = (timer_q[i] == TO_LAST);
      rearm_nxt = rearm_q[i] | intr_req[i];
      unique case (state_q[i])
        IDLE: begin
          if (intr_req[i]) state_d[i] = PEND;
        end
        PEND: begin
          if (gnt_oh_c[i]) begin
            state_d[i] = WAIT;
            timer_d[i] = '0;
          end
        end
        WAIT: begin
          if (rsp_hit || expire) begin
            state_d[i] = rearm_nxt ? PEND : IDLE;
            rearm_d[i] = 1'b0;
            if (!rsp_hit) err_to_d[i] = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] + TIMER_W'(1);
            rearm_d[i] = rearm_nxt;
          end
        end
        default: state_d[i] = IDLE;
      endcase
      pend_d[i]  = (state_d[i] == PEND);
      outst_d[i] = (state_d[i] == WAIT);
    end

    tx_d.valid = gnt_vld_c;
    tx_d.id    = gnt_vld_c ? gnt_id_c : tx_q.id;
  end

  // State and output registers.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      for (int unsigned i = 0; i < NUM_ID; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
      rearm_q  <= '0;
      err_to_q <= '0;
      err_sp_q <= 1'b0;
      pend_q   <= '0;
      outst_q  <= '0;
      tx_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ID; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      rearm_q  <= rearm_d;
      err_to_q <= err_to_d;
      err_sp_q <= err_sp_d;
      pend_q   <= pend_d;
      outst_q  <= outst_d;
      tx_q     <= tx_d;
    end
  end

  assign c1_tx_valid   = tx_q.valid;
  assign c1_tx_intr_id = tx_q.id;
  assign pending       = pend_q;
  assign outstanding   = outst_q;
  assign err_timeout   = err_to_q;
  assign err_spurious  = err_sp_q;

`ifdef INTR_SCHED_STATS_EN
  localparam int unsigned SUM_W = STAT_W + 1;

  logic [NUM_ID-1:0]             coal_c;
  logic [SUM_W-1:0]              coal_sum;
  logic [NUM_ID-1:0][STAT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [STAT_W-1:0]             coal_cnt_q, coal_cnt_d;

  // A request is coalesced when it changes nothing: in PEND, or in WAIT with rearm already set.
  always_comb begin
    coal_c      = '0;
    issue_cnt_d = issue_cnt_q;
    for (int unsigned i = 0; i < NUM_ID; i++) begin
      coal_c[i] = intr_req[i] &&
                  ((state_q[i] == PEND) || ((state_q[i] == WAIT) && rearm_q[i]));
      if (gnt_oh_c[i] && (issue_cnt_q[i] != '1)) begin
        issue_cnt_d[i] = issue_cnt_q[i] + STAT_W'(1);
      end
    end
    coal_sum   = SUM_W'(coal_cnt_q) + SUM_W'($countones(coal_c));
    coal_cnt_d = coal_sum[STAT_W] ? '1 : coal_sum[STAT_W-1:0];
    if (err_clr) begin
      issue_cnt_d = '0;
      coal_cnt_d  = '0;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      issue_cnt_q <= '0;
      coal_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      coal_cnt_q  <= coal_cnt_d;
    end
  end

  assign stats_issue_cnt    = issue_cnt_q;
  assign stats_coalesce_cnt = coal_cnt_q;
`endif

endmodule

// File: tb/tb_ccip_intr_scheduler.sv
// Bench for ccip_intr_scheduler: vector table, directed corner sequences and
// randomized traffic against a deadline-based reference model.
module tb_ccip_intr_scheduler;

  localparam int TO     = 16;
  localparam int S_IDLE = 0;
  localparam int S_PEND = 1;
  localparam int S_WAIT = 2;

  logic        clk = 1'b0;
  logic        SoftReset_n = 1'b0;
  logic [3:0]  intr_req = '0;
  logic        c1_busy = 1'b0;
  logic        c1TxAlmFull = 1'b0;
  logic        c1_rsp_intr_valid = 1'b0;
  logic [1:0]  c1_rsp_intr_id = '0;
  logic        err_clr = 1'b0;
  logic        c1_tx_valid;
  logic [1:0]  c1_tx_intr_id;
  logic [3:0]  pending, outstanding, err_timeout;
  logic        err_spurious;
`ifdef INTR_SCHED_STATS_EN
  logic [63:0] stats_issue_cnt;
  logic [15:0] stats_coalesce_cnt;
`endif

  always #5 clk = ~clk;

  ccip_intr_scheduler #(
    .NUM_ID         (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk_400           (clk),
    .SoftReset_n       (SoftReset_n),
    .intr_req          (intr_req),
    .c1_busy           (c1_busy),
    .c1TxAlmFull       (c1TxAlmFull),
    .c1_tx_valid       (c1_tx_valid),
    .c1_tx_intr_id     (c1_tx_intr_id),
    .c1_rsp_intr_valid (c1_rsp_intr_valid),
    .c1_rsp_intr_id    (c1_rsp_intr_id),
    .err_clr           (err_clr),
    .pending           (pending),
    .outstanding       (outstanding),
    .err_timeout       (err_timeout),
    .err_spurious      (err_spurious)
`ifdef INTR_SCHED_STATS_EN
    ,
    .stats_issue_cnt    (stats_issue_cnt),
    .stats_coalesce_cnt (stats_coalesce_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-ID phase, rearm flag and the edge number of the issue.
  int         m_st   [4];
  bit         m_rearm[4];
  int         m_iss  [4];
  int         m_icnt [4];
  int         m_coal;
  int         m_last;
  int         m_edge;
  logic [3:0] m_to;
  logic       m_sp;
  logic       m_v;
  logic [1:0] m_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_vec(input int s);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (m_st[i] == s);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = S_IDLE; m_rearm[i] = 1'b0; m_iss[i] = 0; m_icnt[i] = 0;
    end
    m_coal = 0; m_last = 0; m_edge = 0;
    m_to = '0; m_sp = 1'b0; m_v = 1'b0; m_id = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int         g;
    logic       nsp;
    logic [3:0] nto;
    logic       hit, expired;
    m_edge++;
    g   = -1;
    nto = '0;
    nsp = c1_rsp_intr_valid && (m_st[c1_rsp_intr_id] != S_WAIT);
    if (!c1_busy && !c1TxAlmFull) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && m_st[(m_last + k) % 4] == S_PEND) g = (m_last + k) % 4;
      end
    end
    for (int i = 0; i < 4; i++) begin
      hit = c1_rsp_intr_valid && (c1_rsp_intr_id == 2'(i));
      if (m_st[i] == S_IDLE) begin
        if (intr_req[i]) m_st[i] = S_PEND;
      end else if (m_st[i] == S_PEND) begin
        if (intr_req[i]) m_coal++;
        if (g == i) begin
          m_st[i] = S_WAIT; m_iss[i] = m_edge; m_icnt[i]++;
        end
      end else begin
        expired = (m_edge - m_iss[i]) >= TO;
        if (intr_req[i]) begin
          if (m_rearm[i]) m_coal++;
          else m_rearm[i] = 1'b1;
        end
        if (hit || expired) begin
          if (!hit) nto[i] = 1'b1;
          m_st[i]    = m_rearm[i] ? S_PEND : S_IDLE;
          m_rearm[i] = 1'b0;
        end
      end
    end
    if (err_clr) begin
      m_to = '0; m_sp = 1'b0; m_coal = 0;
      for (int i = 0; i < 4; i++) m_icnt[i] = 0;
    end
    m_to = m_to | nto;
    m_sp = m_sp | nsp;
    m_v  = (g >= 0);
    if (g >= 0) begin
      m_id   = 2'(g);
      m_last = g;
    end
  endtask

  task automatic check_model();
    chk("mdl_valid", 32'(c1_tx_valid), 32'(m_v));
    if (m_v) chk("mdl_id", 32'(c1_tx_intr_id), 32'(m_id));
    chk("mdl_pending", 32'(pending), 32'(m_vec(S_PEND)));
    chk("mdl_outstanding", 32'(outstanding), 32'(m_vec(S_WAIT)));
    chk("mdl_err_timeout", 32'(err_timeout), 32'(m_to));
    chk("mdl_err_spurious", 32'(err_spurious), 32'(m_sp));
`ifdef INTR_SCHED_STATS_EN
    chk("mdl_coal_cnt", 32'(stats_coalesce_cnt), 32'(m_coal));
    for (int i = 0; i < 4; i++) chk("mdl_issue_cnt", 32'(stats_issue_cnt[i*16 +: 16]), 32'(m_icnt[i]));
`endif
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, check 1 ns later.
  task automatic step(input logic [3:0] req, input logic busy, input logic alm,
                      input logic rv, input logic [1:0] rid, input logic clr);
    @(negedge clk);
    intr_req = req; c1_busy = busy; c1TxAlmFull = alm;
    c1_rsp_intr_valid = rv; c1_rsp_intr_id = rid; err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle();
    step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic rsp(input logic [1:0] id);
    step(4'b0000, 1'b0, 1'b0, 1'b1, id, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must drop without a clock.
  task automatic do_reset();
    @(negedge clk);
    intr_req = '0; c1_busy = 1'b0; c1TxAlmFull = 1'b0;
    c1_rsp_intr_valid = 1'b0; c1_rsp_intr_id = '0; err_clr = 1'b0;
    #2;
    SoftReset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(c1_tx_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_err_spurious", 32'(err_spurious), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    SoftReset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rv;
    logic [1:0] rid;
    logic       v;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] outs;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] req, input logic rv, input logic [1:0] rid,
                              input logic v, input logic [1:0] id,
                              input logic [3:0] pend, input logic [3:0] outs);
    vec_t r;
    r.req = req; r.rv = rv; r.rid = rid; r.v = v; r.id = id; r.pend = pend; r.outs = outs;
    return r;
  endfunction

  task automatic run_random(input int ncyc);
    logic [3:0] req;
    logic       busy, alm, rv, clr;
    logic [1:0] rid;
    int         s;
    for (int n = 0; n < ncyc; n++) begin
      for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 7) == 0);
      busy = ($urandom_range(0, 3) == 0);
      alm  = ($urandom_range(0, 5) == 0);
      rv   = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 49) == 0);
      rid  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) != 0) begin
        s = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++) begin
          if (m_st[(s + k) % 4] == S_WAIT) begin
            rid = 2'((s + k) % 4);
            break;
          end
        end
      end
      step(req, busy, alm, rv, rid, clr);
    end
  endtask

  vec_t tbl [22];
  int   issues;

  initial begin
    // Fairness from a fresh pointer, then a single-ID round trip.
    tbl[0]  = mk(4'b1111, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1111, 4'b0000);
    tbl[1]  = mk(4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b1101, 4'b0010);
    tbl[2]  = mk(4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, 4'b1001, 4'b0110);
    tbl[3]  = mk(4'b0000, 1'b0, 2'd0, 1'b1, 2'd3, 4'b0001, 4'b1110);
    tbl[4]  = mk(4'b0000, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000, 4'b1111);
    tbl[5]  = mk(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b1111);
    tbl[6]  = mk(4'b0000, 1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b1110);
    tbl[7]  = mk(4'b0000, 1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 4'b1100);
    tbl[8]  = mk(4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 4'b1000);
    tbl[9]  = mk(4'b0000, 1'b1, 2'd3, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tbl[10] = mk(4'b0100, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0100, 4'b0000);
    tbl[11] = mk(4'b0000, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0000, 4'b0100);
    for (int r = 12; r < 20; r++) tbl[r] = mk(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0100);
    tbl[20] = mk(4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tbl[21] = mk(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0000);

    model_reset();
    do_reset();
    for (int r = 0; r < 22; r++) begin
      step(tbl[r].req, 1'b0, 1'b0, tbl[r].rv, tbl[r].rid, 1'b0);
      chk($sformatf("tbl%0d_valid", r), 32'(c1_tx_valid), 32'(tbl[r].v));
      if (tbl[r].v) chk($sformatf("tbl%0d_id", r), 32'(c1_tx_intr_id), 32'(tbl[r].id));
      chk($sformatf("tbl%0d_pending", r), 32'(pending), 32'(tbl[r].pend));
      chk($sformatf("tbl%0d_outstanding", r), 32'(outstanding), 32'(tbl[r].outs));
    end
    chk("tbl_no_errors", 32'({err_timeout, err_spurious}), 32'd0);

    // Almost-full holds a pending ID until it clears.
    do_reset();
    step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("bp_pending", 32'(pending), 32'b0001);
    for (int c = 1; c <= 20; c++) begin
      step(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      chk("bp_hold_valid", 32'(c1_tx_valid), 32'd0);
    end
    chk("bp_still_pending", 32'(pending), 32'b0001);
    idle();
    chk("bp_release_valid", 32'(c1_tx_valid), 32'd1);
    chk("bp_release_id", 32'(c1_tx_intr_id), 32'd0);
    chk("bp_release_outstanding", 32'(outstanding), 32'b0001);
    rsp(2'd0);

    // Toggling c1_busy: issues only follow cycles with busy low.
    step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    issues = 0;
    for (int c = 0; c < 8; c++) begin
      step(4'b0000, (c % 2 == 0), 1'b0, 1'b0, 2'd0, 1'b0);
      chk("busy_gate", 32'(c1_tx_valid), 32'(c % 2 != 0));
      if (c1_tx_valid) issues++;
    end
    chk("busy_issue_count", 32'(issues), 32'd4);
    for (int k = 0; k < 4; k++) rsp(2'(k));
    chk("busy_drained", 32'(outstanding), 32'd0);

    // Coalesce: three requests during WAIT give exactly one re-issue.
    do_reset();
    step(4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle();
    chk("coal_first_issue", 32'({c1_tx_valid, c1_tx_intr_id}), 32'b111);
    for (int k = 0; k < 3; k++) step(4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("coal_wait_outstanding", 32'(outstanding), 32'b1000);
    chk("coal_wait_pending", 32'(pending), 32'b0000);
    rsp(2'd3);
    chk("coal_rearm_pending", 32'(pending), 32'b1000);
    issues = 0;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c1_tx_valid && c1_tx_intr_id == 2'd3) issues++;
    end
    chk("coal_reissue_count", 32'(issues), 32'd1);
`ifdef INTR_SCHED_STATS_EN
    chk("coal_stats_cnt", 32'(stats_coalesce_cnt), 32'd2);
    chk("coal_stats_issue3", 32'(stats_issue_cnt[63:48]), 32'd2);
`endif
    rsp(2'd3);

    // Timeout 16 cycles after the issue cycle; a response on the last WAIT cycle wins.
    do_reset();
    step(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle();
    chk("to_issue", 32'({c1_tx_valid, c1_tx_intr_id}), 32'b101);
    for (int k = 1; k <= 15; k++) idle();
    chk("to_before_outstanding", 32'(outstanding), 32'b0010);
    chk("to_before_err", 32'(err_timeout), 32'd0);
    idle();
    chk("to_fire_outstanding", 32'(outstanding), 32'd0);
    chk("to_fire_err", 32'(err_timeout), 32'b0010);
    idle();
    chk("to_sticky", 32'(err_timeout), 32'b0010);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("to_cleared", 32'(err_timeout), 32'd0);
    step(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle();
    for (int k = 1; k <= 15; k++) idle();
    rsp(2'd1);
    chk("to_race_outstanding", 32'(outstanding), 32'd0);
    chk("to_race_no_timeout", 32'(err_timeout), 32'd0);
    chk("to_race_no_spurious", 32'(err_spurious), 32'd0);

    // Spurious responses, clear priority, and reset in the middle of WAIT.
    do_reset();
    rsp(2'd0);
    chk("sp_set", 32'(err_spurious), 32'd1);
    for (int k = 0; k < 3; k++) idle();
    chk("sp_sticky", 32'(err_spurious), 32'd1);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("sp_cleared", 32'(err_spurious), 32'd0);
    step(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
    chk("sp_error_beats_clear", 32'(err_spurious), 32'd1);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    chk("sp_pend_rsp_spurious", 32'(err_spurious), 32'd1);
    chk("sp_pend_rsp_issued", 32'(outstanding), 32'b0010);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    idle();
    chk("rst_mid_wait_pre", 32'(outstanding), 32'b0010);
    do_reset();
    rsp(2'd1);
    chk("rst_stale_rsp_spurious", 32'(err_spurious), 32'd1);
    chk("rst_stale_rsp_outstanding", 32'(outstanding), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    run_random(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ccip_intr_scheduler.md
Name: ccip_intr_scheduler

Overview:
- Shares the CCI-P c1 Tx channel's interrupt capability among four user interrupt sources, one per 2-bit CCI-P interrupt ID.
- Sequences each ID through request, issue and response; coalesces repeat requests; times out lost responses.
- Sits between user logic and the c1 Tx mux of the AFU. It issues only when the c1 mux reports the channel free and the shim is not almost-full.

Parameters:
- NUM_ID, 4, number of interrupt sources; fixed to the CCI-P 2-bit ID space, other values unsupported.
- TIMEOUT_CYCLES, 65535, cycles to wait for an interrupt response before abandoning it (1..65535).

Ports:
- Clk_400  in  1  core clock; all logic synchronous to it.
- SoftReset_n  in  1  asynchronous, active-low reset.
- intr_req  in  NUM_ID  per-ID request pulse; a level is treated as a pulse per cycle.
- c1_busy  in  1  another c1 source owns the c1 Tx channel this cycle.
- c1TxAlmFull  in  1  c1 Tx almost-full from the shim.
- c1_tx_valid  out  1  interrupt request valid (eREQ_INTR) to the c1 mux.
- c1_tx_intr_id  out  2  ID of the issued interrupt.
- c1_rsp_intr_valid  in  1  c1 Rx response of type eRSP_INTR.
- c1_rsp_intr_id  in  2  ID carried by that response.
- err_clr  in  1  clears the sticky error flags.
- pending  out  NUM_ID  ID queued, not yet issued.
- outstanding  out  NUM_ID  ID issued, awaiting response.
- err_timeout  out  NUM_ID  sticky: response never arrived for that ID.
- err_spurious  out  1  sticky: response received for a non-outstanding ID.

Behaviour:
- Reset: all outputs 0; every ID in IDLE; all timers 0; RR pointer at ID 0.
- Per-ID state machine:
  - IDLE -> PEND on intr_req[i].
  - PEND -> WAIT on issue.
  - WAIT -> IDLE on response or timeout.
  - WAIT with rearm set -> PEND on response or timeout, then rearm clears.
- Coalescing:
  - intr_req[i] in PEND: no effect.
  - intr_req[i] in WAIT: sets rearm[i]; further requests in WAIT have no effect.
- Issue eligibility: at least one ID in PEND, c1_busy=0 and c1TxAlmFull=0.
- Arbitration:
  - Round-robin over PEND IDs, starting at the ID after the last granted one.
  - At most one issue per cycle.
- Issue outputs: c1_tx_valid and c1_tx_intr_id are registered and high for exactly 1 cycle per issue.
- Latency, with eligibility held: intr_req high in cycle 0 -> pending[i] high in cycle 1 -> c1_tx_valid high in cycle 2.
- Issue timing:
  - pending[i] falls and outstanding[i] rises in the same cycle c1_tx_valid rises.
  - c1_busy or almost-full holds all issues; PEND states are retained.
- Timer:
  - Per-ID 16-bit timer loads 0 on issue and increments while in WAIT.
  - When it reaches TIMEOUT_CYCLES: set err_timeout[i] and leave WAIT as above.
- Response:
  - c1_rsp_intr_valid with ID in WAIT: leave WAIT as above.
  - With ID not in WAIT: set err_spurious; state unchanged.
- Simultaneous events:
  - Response and timeout in the same cycle: the response wins, no error.
  - intr_req[i] in the same cycle as a response for i: rearm is honoured, ID goes to PEND.
  - err_clr together with a new error: the error wins and stays set.
- Reset mid-operation returns all IDs to IDLE. Responses arriving after reset for pre-reset issues flag err_spurious.

Optional Feature:
- Macro: INTR_SCHED_STATS_EN.
- Defined:
  - Adds output stats_issue_cnt (NUM_ID*16 bits): per-ID saturating issue counters.
  - Adds output stats_coalesce_cnt (16 bits): saturating count of coalesced requests.
  - All counters cleared by err_clr and by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ccip_intr_sched_pkg:
  - NUM_INTR_ID=4.
  - typedef t_intr_id (logic [1:0]).
  - typedef t_intr_state enum {IDLE, PEND, WAIT}.
  - TIMER_W=16.
- Sub-module intr_rr_arbiter:
  - NUM_ID-wide request in, one-hot grant plus encoded ID out, with grant-enable.
  - Owns the RR pointer.

Test Plan:
- Single ID: pulse intr_req=4'b0100 in cycle 0, no backpressure -> c1_tx_valid=1 with id=2 in cycle 2; response id 2 at cycle 10 -> outstanding=0 at cycle 11.
- Fairness: intr_req=4'b1111 held for 1 cycle, RR pointer at 0 -> issues in order id 1,2,3,0 on consecutive cycles; each ID exactly once.
- Backpressure: c1TxAlmFull=1 for cycles 1-20 with ID 0 pending -> no c1_tx_valid until cycle 21; c1_busy toggling each cycle -> issues only in cycles with c1_busy=0.
- Coalesce and rearm: ID 3 in WAIT, intr_req[3] pulsed 3 times -> after response id 3, exactly one re-issue of id 3; stats_coalesce_cnt=2 under INTR_SCHED_STATS_EN.
- Timeout: TIMEOUT_CYCLES=16, issue id 1, no response -> err_timeout=4'b0010 and outstanding[1]=0 16 cycles after issue; a response at cycle 16 instead -> no error.
- Errors and reset: response id 0 while ID 0 is IDLE -> err_spurious=1 until err_clr. SoftReset_n asserted mid-WAIT -> all outputs 0 asynchronously.
